// File: rtl/gated_sr_latch_sequencer.sv
// Round-robin sequencer sharing one gated SR latch between requesters.
// Drives S/R setup, EN pulse, S/R hold and a completion pulse.
module gated_sr_latch_sequencer #(
  parameter int N_REQ       = 4,
  parameter int EN_CYCLES   = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_s,
  input  logic [N_REQ-1:0] req_r,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic             busy,
  output logic             latch_s,
  output logic             latch_r,
  output logic             latch_en
);

  localparam int MAXC = (EN_CYCLES > HOLD_CYCLES) ?
                        EN_CYCLES : HOLD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int PW = $clog2(N_REQ);

  localparam logic [CW-1:0] EN_LAST   = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);
  localparam logic [PW:0]   N_WIDE    = (PW+1)'(N_REQ);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, DONE
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [PW-1:0]    ptr, ptr_d;
  logic [PW-1:0]    idx, idx_d;
  logic             s_q, r_q, s_d, r_d;
  logic [N_REQ-1:0] gnt_d;
  logic [N_REQ-1:0] pick;
  logic [PW-1:0]    pick_idx;
  logic             found;
  logic [PW:0]      sum;
  logic [PW-1:0]    j;
  logic             sr_d;

  // first requester at or above ptr, wrapping
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    sum      = '0;
    j        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= N_WIDE)
        sum = sum - N_WIDE;
      j = sum[PW-1:0];
      if (!found && req[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = j;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    ptr_d   = ptr;
    idx_d   = idx;
    gnt_d   = gnt;
    s_d     = s_q;
    r_d     = r_q;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          gnt_d   = pick;
          idx_d   = pick_idx;
          s_d     = req_s[pick_idx];
          r_d     = req_r[pick_idx];
          state_d = (req_s[pick_idx] && req_r[pick_idx]) ?
                    DONE : SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = PULSE;
      end
      PULSE: begin
        if (cnt == EN_LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        gnt_d   = '0;
        state_d = IDLE;
        ptr_d   = (idx == LAST_IDX) ? '0 : idx + PW'(1);
      end
      default: begin
        cnt_d   = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign sr_d = (state_d == SETUP) ||
                (state_d == PULSE) ||
                (state_d == HOLD);

  // outputs are registered from the next-state view
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      idx      <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      latch_s  <= 1'b0;
      latch_r  <= 1'b0;
      latch_en <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ptr      <= ptr_d;
      idx      <= idx_d;
      s_q      <= s_d;
      r_q      <= r_d;
      gnt      <= gnt_d;
      done     <= (state_d == DONE) ? gnt_d : '0;
      err      <= (state_d == DONE) && s_d && r_d;
      busy     <= (state_d != IDLE);
      latch_s  <= sr_d && s_d;
      latch_r  <= sr_d && r_d;
      latch_en <= (state_d == PULSE);
    end
  end

endmodule

// File: tb/tb_gated_sr_latch_sequencer.sv
// Scoreboard bench for gated_sr_latch_sequencer.
// Expected ops are queued at drive time, checked on done.
module tb_gated_sr_latch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req_s, req_r;
  logic [3:0] gnt, done;
  logic       err, busy;
  logic       latch_s, latch_r, latch_en;

  always #5 clk = ~clk;

  gated_sr_latch_sequencer #(
    .N_REQ(4),
    .EN_CYCLES(2),
    .HOLD_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_s(req_s),
    .req_r(req_r),
    .gnt(gnt),
    .done(done),
    .err(err),
    .busy(busy),
    .latch_s(latch_s),
    .latch_r(latch_r),
    .latch_en(latch_en)
  );

  typedef struct {
    int idx;
    bit s;
    bit r;
    bit bad;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   want = 0;

  int         cyc = 0;
  int         last_rise = 0;
  int         cur_gap = 0;
  int         occ = 0;
  int         ens = 0;
  int         ss = 0;
  int         rs = 0;
  logic [3:0] pg = '0;
  exp_t       e;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int idx, input bit s,
                      input bit r, input int gap);
    sb.push_back('{idx, s, r, s & r, gap});
    want++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    int b = 0;
    while (done_seen < target && b < 300) begin
      step();
      b++;
    end
    if (done_seen < target)
      chk("timeout", 32'(done_seen), 32'(target));
  endtask

  task automatic wait_en();
    int b = 0;
    while (!latch_en && b < 50) begin
      step();
      b++;
    end
    chk("en_seen", 32'(latch_en), 32'h1);
  endtask

  // monitor: per-op phase statistics, scoreboard pop on done
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pg = '0;
      end else begin
        if (gnt == '0)
          chk("idle_out",
              32'({latch_en, latch_s, latch_r}), 32'h0);
        if (gnt != '0 && pg == '0) begin
          cur_gap   = cyc - last_rise;
          last_rise = cyc;
          occ = 0;
          ens = 0;
          ss  = 0;
          rs  = 0;
        end
        if (gnt != '0) begin
          occ++;
          ens += 32'(latch_en);
          ss  += 32'(latch_s);
          rs  += 32'(latch_r);
        end
        if (done != '0) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 32'(done), 32'h0);
          end else begin
            e = sb.pop_front();
            chk("done", 32'(done), 32'(1) << e.idx);
            chk("gnt_at_done", 32'(gnt), 32'(1) << e.idx);
            chk("err", 32'(err), 32'(e.bad));
            chk("busy", 32'(busy), 32'h1);
            chk("occupancy", 32'(occ), e.bad ? 32'd1 : 32'd5);
            chk("en_cycles", 32'(ens), e.bad ? 32'd0 : 32'd2);
            chk("s_cycles", 32'(ss),
                (!e.bad && e.s) ? 32'd4 : 32'd0);
            chk("r_cycles", 32'(rs),
                (!e.bad && e.r) ? 32'd4 : 32'd0);
            if (e.gap != 0)
              chk("gap", 32'(cur_gap), 32'(e.gap));
            done_seen++;
          end
        end
        pg = gnt;
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req   = 4'b1111;
    req_s = '0;
    req_r = '0;
    repeat (3) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_out",
          32'({done, err, latch_s, latch_r, latch_en}), 32'h0);
    end
    req = '0;
    rst = 1'b0;
    step();
    step();

    // single set on requester 2
    push(2, 1'b1, 1'b0, 0);
    req_s = 4'b0100;
    req   = 4'b0100;
    step();
    chk("set_gnt", 32'(gnt), 32'h4);
    wait_done(want);
    req   = '0;
    req_s = '0;
    step();

    // illegal S=R=1 on requester 1
    push(1, 1'b1, 1'b1, 0);
    req   = 4'b0010;
    req_s = 4'b0010;
    req_r = 4'b0010;
    wait_done(want);
    req   = '0;
    req_s = '0;
    req_r = '0;
    step();

    // S changes after grant; captured value must hold
    push(0, 1'b1, 1'b0, 0);
    req   = 4'b0001;
    req_s = 4'b0001;
    wait_en();
    req_s = '0;
    wait_done(want);
    req = '0;
    step();

    // S=R=0 still runs the full sequence
    push(3, 1'b0, 1'b0, 0);
    req = 4'b1000;
    wait_done(want);
    req = '0;
    step();

    // round robin with 0,1,3 held
    req_s = 4'b0001;
    req_r = 4'b1010;
    push(0, 1'b1, 1'b0, 0);
    push(1, 1'b0, 1'b1, 6);
    push(3, 1'b0, 1'b1, 6);
    push(0, 1'b1, 1'b0, 6);
    push(1, 1'b0, 1'b1, 6);
    push(3, 1'b0, 1'b1, 6);
    req = 4'b1011;
    wait_done(want);
    req   = '0;
    req_s = '0;
    req_r = '0;
    step();

    // move the pointer off zero
    push(0, 1'b1, 1'b0, 0);
    req   = 4'b0001;
    req_s = 4'b0001;
    wait_done(want);
    req   = '0;
    req_s = '0;
    step();

    // reset during the first EN cycle
    req   = 4'b0100;
    req_s = 4'b0100;
    wait_en();
    rst   = 1'b1;
    req   = 4'b0101;
    req_s = 4'b0101;
    step();
    chk("mid_en", 32'(latch_en), 32'h0);
    chk("mid_gnt", 32'(gnt), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    push(0, 1'b1, 1'b0, 0);
    push(2, 1'b1, 1'b0, 6);
    rst = 1'b0;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    wait_done(want - 1);
    req[0] = 1'b0;
    wait_done(want);
    req   = '0;
    req_s = '0;
    step();
    step();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
